// File: rtl/mmio_defs_pkg.sv
// Shared CPU memory-bus definitions: command encodings, peripheral addresses and timer register layout.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mmio_defs;

    // mem_cmd encodings: bit 1 = read, bit 0 = write
    localparam logic [1:0] MEM_CMD_NONE = 2'b00;
    localparam logic [1:0] MEM_CMD_RD   = 2'b10;
    localparam logic [1:0] MEM_CMD_WR   = 2'b01;

    // Word addresses of the memory-mapped peripherals
    localparam logic [8:0] LED_ADDR   = 9'h100;
    localparam logic [8:0] SW_ADDR    = 9'h140;
    localparam logic [8:0] TIMER_BASE = 9'h180;

    // Timer register offsets (mem_addr[1:0])
    localparam logic [1:0] TIMER_OFS_CTRL   = 2'd0;
    localparam logic [1:0] TIMER_OFS_PERIOD = 2'd1;
    localparam logic [1:0] TIMER_OFS_COUNT  = 2'd2;
    localparam logic [1:0] TIMER_OFS_STATUS = 2'd3;

    // CTRL / STATUS bit positions
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_AUTO_BIT  = 1;
    localparam int CTRL_IE_BIT    = 2;
    localparam int STATUS_EXP_BIT = 0;

endpackage

// File: rtl/mmio_timer_prescaler.sv
// Prescaler for mmio_timer: counts 0..PRESCALE-1 while en, pulses tick on the last count.
// Latency: tick is combinational from the registered count; first tick PRESCALE cycles after clr.
// Backpressure: none; en=0 freezes the count, clr forces it to 0.
// Ports: clk, reset_n (sync, active-low), en (count enable), clr (restart), tick (one-cycle pulse).
module timer_prescaler #(
    parameter int PRESCALE = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] r_psc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_psc <= 16'd0;
        end else if (clr) begin
            r_psc <= 16'd0;
        end else if (en) begin
            r_psc <= (r_psc == LAST) ? 16'd0 : r_psc + 16'd1;
        end
    end

    assign tick = en & (r_psc == LAST);

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer on the CPU word bus (CTRL/PERIOD/COUNT/STATUS at BASE..BASE+3).
// Latency: writes take effect on the strobe edge; reads return 1 cycle after address (like RAM).
// Backpressure: none; read_data is driven only while this block is the selected read target, else 'z.
// Ports: clk, reset_n (sync, active-low), mem_addr/mem_cmd/write_data (CPU bus in),
//        read_data (shared tri-state read bus), irq (expiry interrupt).
// Build option: define MMIO_TIMER_IRQ_EN to implement CTRL[2]=IE and irq = EXP & IE; otherwise irq = 0.
module mmio_timer
    import mmio_defs::*;
#(
    parameter logic [8:0] BASE     = TIMER_BASE,
    parameter int         PRESCALE = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [8:0]  mem_addr,
    input  logic [1:0]  mem_cmd,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        irq
);

    logic        r_en;
    logic        r_auto;
    logic [15:0] r_period;
    logic [15:0] r_count;
    logic        r_exp;
    logic [15:0] r_dout;

    logic        w_sel;
    logic [1:0]  w_ofs;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_period;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_zero;
    logic        w_expire;
    logic        w_psc_clr;
    logic        w_ie;
    logic [15:0] w_rd_mux;

    assign w_sel       = (mem_addr[8:2] == BASE[8:2]);
    assign w_ofs       = mem_addr[1:0];
    assign w_wr        = w_sel & mem_cmd[0];
    assign w_wr_ctrl   = w_wr & (w_ofs == TIMER_OFS_CTRL);
    assign w_wr_period = w_wr & (w_ofs == TIMER_OFS_PERIOD);
    assign w_wr_status = w_wr & (w_ofs == TIMER_OFS_STATUS);

    assign w_zero   = (r_count == 16'd0);
    assign w_expire = w_tick & w_zero;

    // Restart the prescaler on a PERIOD write and on an EN 0->1 transition so
    // the first tick lands exactly PRESCALE cycles later.
    assign w_psc_clr = w_wr_period | (w_wr_ctrl & write_data[CTRL_EN_BIT] & ~r_en);

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_psc (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (r_en),
        .clr     (w_psc_clr),
        .tick    (w_tick)
    );

    // A software CTRL write takes priority over the one-shot auto-clear of EN.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_en   <= 1'b0;
            r_auto <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_en   <= write_data[CTRL_EN_BIT];
            r_auto <= write_data[CTRL_AUTO_BIT];
        end else if (w_expire && !r_auto) begin
            r_en <= 1'b0;
        end
    end

`ifdef MMIO_TIMER_IRQ_EN
    logic r_ie;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ie <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_ie <= write_data[CTRL_IE_BIT];
        end
    end

    assign w_ie = r_ie;
    assign irq  = r_exp & r_ie;
`else
    assign w_ie = 1'b0;
    assign irq  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_period <= 16'd0;
        end else if (w_wr_period) begin
            r_period <= write_data;
        end
    end

    // A PERIOD write reloads COUNT and overrides any same-cycle tick; COUNT
    // sits at 0 instead of wrapping when a one-shot expires.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= 16'd0;
        end else if (w_wr_period) begin
            r_count <= write_data;
        end else if (w_tick) begin
            if (!w_zero) begin
                r_count <= r_count - 16'd1;
            end else if (r_auto) begin
                r_count <= r_period;
            end
        end
    end

    // Hardware expiry wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_exp <= 1'b0;
        end else if (w_expire) begin
            r_exp <= 1'b1;
        end else if (w_wr_status && write_data[STATUS_EXP_BIT]) begin
            r_exp <= 1'b0;
        end
    end

    always_comb begin
        w_rd_mux = 16'd0;
        case (w_ofs)
            TIMER_OFS_CTRL:   w_rd_mux = {13'd0, w_ie, r_auto, r_en};
            TIMER_OFS_PERIOD: w_rd_mux = r_period;
            TIMER_OFS_COUNT:  w_rd_mux = r_count;
            TIMER_OFS_STATUS: w_rd_mux = {15'd0, r_exp};
            default:          w_rd_mux = 16'd0;
        endcase
    end

    // Read register is loaded every cycle, giving the same 1-cycle latency as RAM.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dout <= 16'd0;
        end else begin
            r_dout <= w_rd_mux;
        end
    end

    assign read_data = (w_sel & mem_cmd[1]) ? r_dout : 16'bz;

endmodule
